// File: rtl/mux2_rr_arbiter_if.sv
// Bundle of the two requester channels, the shared output channel and the arbiter status.
// The arbiter connects through 'master'; the requesters/downstream side uses 'slave'.
interface mux2_rr_arbiter_if #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
);
  localparam int CW = $clog2(MAX_BEATS + 1);

  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_last;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_last;
  logic             req1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_ready;
  logic             sel;
  logic             busy;
  logic             err_long;
  // Observation of the FSM: 0 = IDLE, 1 = GNT0, 2 = GNT1.
  logic [1:0]       dbg_state;
  logic [CW-1:0]    dbg_beat_cnt;

  modport master (
    input  req0_valid, req0_data, req0_last,
    input  req1_valid, req1_data, req1_last,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_data, out_last,
    output sel, busy, err_long, dbg_state, dbg_beat_cnt
  );

  modport slave (
    output req0_valid, req0_data, req0_last,
    output req1_valid, req1_data, req1_last,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_data, out_last,
    input  sel, busy, err_long, dbg_state, dbg_beat_cnt
  );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Packet-level round-robin arbiter driving the select of a shared 2:1 mux channel.
// Handshake: a beat moves on any rising edge where valid & ready are both high; ready never waits on nothing but out_ready.
module mux2_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mux2_rr_arbiter_if.master    bus
);
  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          prio_q, prio_d;
  logic          sel_q, sel_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic          err_long_q, err_long_d;

  logic          gnt_x;
  logic          cur_valid;
  logic          cur_last;
  logic          oth_valid;
  logic          accept;
  logic [CW-1:0] cnt_inc;
  logic          out_valid_c;
  logic          out_last_c;
  logic          req0_ready_c;
  logic          req1_ready_c;

  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    sel_d        = sel_q;
    beat_cnt_d   = beat_cnt_q;
    err_long_d   = err_long_q;
    out_valid_c  = 1'b0;
    out_last_c   = 1'b0;
    req0_ready_c = 1'b0;
    req1_ready_c = 1'b0;
    accept       = 1'b0;
    gnt_x        = (state_q == GNT1);
    cur_valid    = gnt_x ? bus.req1_valid : bus.req0_valid;
    cur_last     = gnt_x ? bus.req1_last  : bus.req0_last;
    oth_valid    = gnt_x ? bus.req0_valid : bus.req1_valid;
    cnt_inc      = beat_cnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (bus.req0_valid && (!bus.req1_valid || !prio_q)) begin
          state_d = GNT0;
          sel_d   = 1'b0;
        end else if (bus.req1_valid) begin
          state_d = GNT1;
          sel_d   = 1'b1;
        end
      end
      GNT0, GNT1: begin
        out_valid_c  = cur_valid;
        out_last_c   = cur_last;
        req0_ready_c = !gnt_x & bus.out_ready;
        req1_ready_c =  gnt_x & bus.out_ready;
        accept       = cur_valid & bus.out_ready;
        if (accept) begin
          if (cur_last || (cnt_inc == CW'(MAX_BEATS))) begin
            beat_cnt_d = '0;
            prio_d     = ~gnt_x;
            if (!cur_last) err_long_d = 1'b1;
            // The other side wins a handover; the granted side is still valid on its accepting beat, so it keeps the grant otherwise.
            if (oth_valid) begin
              state_d = gnt_x ? GNT0 : GNT1;
              sel_d   = ~gnt_x;
            end else if (cur_valid) begin
              state_d = state_q;
            end else begin
              state_d = IDLE;
            end
          end else begin
            beat_cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Nothing may transfer in a reset cycle, even mid-packet.
    if (rst) begin
      out_valid_c  = 1'b0;
      req0_ready_c = 1'b0;
      req1_ready_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      sel_q      <= 1'b0;
      beat_cnt_q <= '0;
      err_long_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      sel_q      <= sel_d;
      beat_cnt_q <= beat_cnt_d;
      err_long_q <= err_long_d;
    end
  end

  assign bus.out_valid    = out_valid_c;
  assign bus.out_last     = out_last_c;
  assign bus.out_data     = sel_q ? bus.req1_data : bus.req0_data;
  assign bus.req0_ready   = req0_ready_c;
  assign bus.req1_ready   = req1_ready_c;
  assign bus.sel          = sel_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.err_long     = err_long_q;
  assign bus.dbg_state    = state_q;
  assign bus.dbg_beat_cnt = beat_cnt_q;
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: handover, round robin, stall, forced release and reset abort.
// Inputs change at falling edges; outputs are checked 1 time unit later, away from the rising edge.
module tb_mux2_rr_arbiter;
  localparam int WIDTH     = 8;
  localparam int MAX_BEATS = 16;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   acc0;
  int   acc1;

  mux2_rr_arbiter_if #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) bus ();

  mux2_rr_arbiter #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_last = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_last = 1'b0;
    bus.out_ready  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    // Reset state
    do_reset();
    settle();
    chk("rst_state", bus.dbg_state, 0);
    chk("rst_sel", bus.sel, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err_long, 0);
    chk("rst_cnt", bus.dbg_beat_cnt, 0);
    chk("rst_out_valid", bus.out_valid, 0);

    // 1: single 3-beat packet from requester 0
    bus.req0_valid = 1'b1; bus.req0_data = 8'h11; bus.out_ready = 1'b1;
    settle();
    chk("t1_idle_out_valid", bus.out_valid, 0);
    chk("t1_idle_ready0", bus.req0_ready, 0);
    next_cycle(); settle();
    chk("t1_state_gnt0", bus.dbg_state, 1);
    chk("t1_sel", bus.sel, 0);
    chk("t1_out_valid", bus.out_valid, 1);
    chk("t1_beat1_data", bus.out_data, 8'h11);
    chk("t1_ready0", bus.req0_ready, 1);
    chk("t1_ready1", bus.req1_ready, 0);
    next_cycle();
    bus.req0_data = 8'h22; settle();
    chk("t1_cnt1", bus.dbg_beat_cnt, 1);
    chk("t1_beat2_data", bus.out_data, 8'h22);
    next_cycle();
    bus.req0_data = 8'h33; bus.req0_last = 1'b1; settle();
    chk("t1_cnt2", bus.dbg_beat_cnt, 2);
    chk("t1_beat3_last", bus.out_last, 1);
    next_cycle();
    bus.req0_valid = 1'b0; bus.req0_last = 1'b0; settle();
    chk("t1_cnt_cleared", bus.dbg_beat_cnt, 0);
    chk("t1_kept_gnt0", bus.dbg_state, 1);
    chk("t1_no_valid", bus.out_valid, 0);

    // 2: both valid from IDLE with prio 0, back-to-back handover
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_data = 8'hA0; bus.req0_last = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_data = 8'hB0; bus.req1_last = 1'b1;
    bus.out_ready  = 1'b1;
    next_cycle(); settle();
    chk("t2_first_gnt0", bus.dbg_state, 1);
    chk("t2_data0", bus.out_data, 8'hA0);
    chk("t2_ready1_low", bus.req1_ready, 0);
    next_cycle(); settle();
    chk("t2_handover_gnt1", bus.dbg_state, 2);
    chk("t2_sel1", bus.sel, 1);
    chk("t2_no_bubble", bus.out_valid, 1);
    chk("t2_data1", bus.out_data, 8'hB0);
    chk("t2_ready0_low", bus.req0_ready, 0);

    // 3: continuous 1-beat packets alternate grants
    acc0 = 0; acc1 = 0;
    for (int i = 0; i < 8; i++) begin
      next_cycle(); settle();
      chk("t3_alternate_sel", bus.sel, (i % 2 == 0) ? 0 : 1);
      if (bus.out_valid && bus.out_ready) begin
        if (bus.sel) acc1++; else acc0++;
      end
    end
    chk("t3_share0", acc0, 4);
    chk("t3_share1", acc1, 4);

    // 4: downstream stall mid-packet
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_data = 8'h5A; bus.out_ready = 1'b1;
    next_cycle(); settle();
    chk("t4_gnt0", bus.dbg_state, 1);
    next_cycle();
    bus.req0_data = 8'h5B; bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t4_stall_data", bus.out_data, 8'h5B);
      chk("t4_stall_ready", bus.req0_ready, 0);
      chk("t4_stall_cnt", bus.dbg_beat_cnt, 1);
      next_cycle();
    end
    bus.out_ready = 1'b1; bus.req0_last = 1'b1; settle();
    chk("t4_resume_data", bus.out_data, 8'h5B);
    chk("t4_resume_ready", bus.req0_ready, 1);
    next_cycle(); settle();
    chk("t4_released_cnt", bus.dbg_beat_cnt, 0);
    chk("t4_no_err", bus.err_long, 0);

    // 5: requester 1 overruns MAX_BEATS without last
    do_reset();
    bus.req1_valid = 1'b1; bus.req1_data = 8'h70; bus.out_ready = 1'b1;
    next_cycle(); settle();
    chk("t5_gnt1", bus.dbg_state, 2);
    chk("t5_cnt0", bus.dbg_beat_cnt, 0);
    for (int i = 1; i < MAX_BEATS; i++) begin
      next_cycle();
      bus.req1_data = 8'(8'h70 + i); settle();
      chk("t5_cnt", bus.dbg_beat_cnt, i);
      chk("t5_err_low", bus.err_long, 0);
    end
    bus.req0_valid = 1'b1; bus.req0_data = 8'hC3;
    next_cycle(); settle();
    chk("t5_err_set", bus.err_long, 1);
    chk("t5_gnt0", bus.dbg_state, 1);
    chk("t5_sel0", bus.sel, 0);
    chk("t5_cnt_cleared", bus.dbg_beat_cnt, 0);
    chk("t5_data_req0", bus.out_data, 8'hC3);
    chk("t5_ready1_low", bus.req1_ready, 0);

    // 6: reset during beat 2 of a packet
    bus.req1_valid = 1'b0;
    next_cycle();
    bus.req0_data = 8'hC4; settle();
    chk("t6_cnt1", bus.dbg_beat_cnt, 1);
    rst = 1'b1; settle();
    chk("t6_no_ready_in_rst", bus.req0_ready, 0);
    chk("t6_no_valid_in_rst", bus.out_valid, 0);
    next_cycle();
    rst = 1'b0; settle();
    chk("t6_idle", bus.dbg_state, 0);
    chk("t6_sel0", bus.sel, 0);
    chk("t6_ready0", bus.req0_ready, 0);
    chk("t6_ready1", bus.req1_ready, 0);
    chk("t6_err_cleared", bus.err_long, 0);
    chk("t6_cnt0", bus.dbg_beat_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
